// File: rtl/fp32_pkg.sv
// fp32_pkg: shared definitions for the sequenced FP32 multiplier and the
// round/pack datapath (also intended for the future FP32 adder).
//   - IEEE-754 single constants and the quiet-NaN pattern
//   - bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
//   - controller state encoding
//   - special-operand screening helper
package fp32_pkg;

    localparam int          FP32_BIAS    = 127;
    localparam int          FP32_EXP_MAX = 255;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] result;
        logic [3:0]  flags;
    } special_t;

    // Classifies an operand pair. Exponent field 0 counts as zero, so
    // denormal inputs are flushed here. Checks run in priority order:
    // NaN, zero*inf, inf*nonzero, zero*finite.
    function automatic special_t screen_special(input logic [31:0] a, input logic [31:0] b);
        special_t s;
        logic     sign;
        logic     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        sign   = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'(FP32_EXP_MAX)) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'(FP32_EXP_MAX)) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'(FP32_EXP_MAX)) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'(FP32_EXP_MAX)) && (b[22:0] != 23'd0);
        s = '0;
        if (a_nan || b_nan) begin
            s.hit    = 1'b1;
            s.result = FP32_QNAN;
        end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            s.hit            = 1'b1;
            s.result         = FP32_QNAN;
            s.flags[FLG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
            s.hit    = 1'b1;
            s.result = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            s.hit    = 1'b1;
            s.result = {sign, 31'd0};
        end
        return s;
    endfunction

endpackage

// File: rtl/fp32_mul_seq_if.sv
// fp32_mul_seq_if: operand/result handshake bundle of fp32_mul_seq.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid, once raised, is held with its payload stable until
// that edge (in_valid/in_ready upstream, out_valid/out_ready downstream).
//   in_valid, in_a, in_b : operand pair from the issue queue
//   in_ready             : multiplier can accept (only when idle)
//   out_valid, out_result, out_flags : product to writeback, flags {inv,ovf,unf,nx}
//   out_ready            : writeback accepts the product
//   busy                 : multiplier is not idle
interface fp32_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags, busy
    );
endinterface

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: combinational normalise / round-to-nearest-even / pack.
//   product_i : 48-bit mantissa product (1.x * 1.x, so bit 47 or 46 is set)
//   sign_i    : result sign
//   e_i       : biased exponent E1+E2-bias, two's complement, 10 bits
//   result_o  : packed IEEE-754 single (flush-to-zero on underflow)
//   flags_o   : {invalid, overflow, underflow, inexact}; invalid is always 0 here
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic [47:0] product_i,
    input  logic        sign_i,
    input  logic [9:0]  e_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);

    logic signed [9:0] e_norm;
    logic signed [9:0] e_fin;
    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [23:0]       mant_rnd;

    always_comb begin
        if (product_i[47]) begin
            mant   = product_i[46:24];
            guard  = product_i[23];
            sticky = |product_i[22:0];
            e_norm = $signed(e_i) + 10'sd1;
        end else begin
            mant   = product_i[45:23];
            guard  = product_i[22];
            sticky = |product_i[21:0];
            e_norm = $signed(e_i);
        end

        inc      = guard & (sticky | mant[0]);
        // A carry out of the 23-bit fraction leaves the low bits at zero,
        // which is exactly the renormalised 1.0 mantissa.
        mant_rnd = {1'b0, mant} + {23'd0, inc};
        e_fin    = e_norm + $signed({9'd0, mant_rnd[23]});

        result_o         = {sign_i, e_fin[7:0], mant_rnd[22:0]};
        flags_o          = 4'd0;
        flags_o[FLG_NX]  = guard | sticky;

        if (e_fin >= 10'sd255) begin
            result_o         = {sign_i, 8'hFF, 23'd0};
            flags_o          = 4'd0;
            flags_o[FLG_OVF] = 1'b1;
            flags_o[FLG_NX]  = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            result_o         = {sign_i, 31'd0};
            flags_o          = 4'd0;
            flags_o[FLG_UNF] = 1'b1;
            flags_o[FLG_NX]  = 1'b1;
        end
    end

endmodule

// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq: sequenced IEEE-754 single-precision multiplier.
// Accepts an operand pair in IDLE, screens special operands in UNPACK,
// multiplies the 24-bit mantissas MUL_RADIX bits per cycle in MUL,
// registers the rounded result in ROUND and presents it in DONE until taken.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   mul_if   : operand/result handshake (slave side), see fp32_mul_seq_if
//   state_o  : current controller state, for observation
// MUL_RADIX must divide 24 (1, 2, 3, 4, 6 or 8).
module fp32_mul_seq
    import fp32_pkg::*;
#(
    parameter int MUL_RADIX = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    fp32_mul_seq_if.slave  mul_if,
    output state_e         state_o
);

    localparam int         STEPS     = 24 / MUL_RADIX;
    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    state_e      state_q,  state_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] b_q,      b_d;
    logic        sign_q,   sign_d;
    logic [9:0]  e_q,      e_d;
    logic [23:0] mcand_q,  mcand_d;
    logic [23:0] mplr_q,   mplr_d;
    logic [47:0] prod_q,   prod_d;
    logic [4:0]  step_q,   step_d;
    logic        spec_q,   spec_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  flags_q,  flags_d;

    logic [MUL_RADIX-1:0]  digit;
    logic [23+MUL_RADIX:0] pp;
    logic [23+MUL_RADIX:0] sum;
    special_t              special;
    logic [31:0]           rp_result;
    logic [3:0]            rp_flags;

    fp32_round_pack u_round_pack (
        .product_i (prod_q),
        .sign_i    (sign_q),
        .e_i       (e_q),
        .result_o  (rp_result),
        .flags_o   (rp_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            e_q      <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            prod_q   <= '0;
            step_q   <= '0;
            spec_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            e_q      <= e_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            prod_q   <= prod_d;
            step_q   <= step_d;
            spec_q   <= spec_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        e_d      = e_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prod_d   = prod_q;
        step_d   = step_q;
        spec_d   = spec_q;
        result_d = result_q;
        flags_d  = flags_q;

        // Shift-add step: the partial product lands on the upper half of the
        // accumulator, then the whole accumulator moves right by one digit.
        digit   = mplr_q[MUL_RADIX-1:0];
        pp      = {{MUL_RADIX{1'b0}}, mcand_q} * {24'd0, digit};
        sum     = {{MUL_RADIX{1'b0}}, prod_q[47:24]} + pp;
        special = screen_special(a_q, b_q);

        case (state_q)
            IDLE: begin
                if (mul_if.in_valid) begin
                    a_d     = mul_if.in_a;
                    b_d     = mul_if.in_b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d = a_q[31] ^ b_q[31];
                e_d    = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'(FP32_BIAS);
                if (special.hit) begin
                    // Special results skip the multiplier but still pass
                    // through ROUND, where the output register is loaded.
                    result_d = special.result;
                    flags_d  = special.flags;
                    spec_d   = 1'b1;
                    state_d  = ROUND;
                end else begin
                    mcand_d = {1'b1, a_q[22:0]};
                    mplr_d  = {1'b1, b_q[22:0]};
                    prod_d  = '0;
                    step_d  = '0;
                    spec_d  = 1'b0;
                    state_d = MULT;
                end
            end
            MULT: begin
                prod_d = {sum, prod_q[23:MUL_RADIX]};
                mplr_d = mplr_q >> MUL_RADIX;
                step_d = step_q + 5'd1;
                if (step_q == LAST_STEP) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (!spec_q) begin
                    result_d = rp_result;
                    flags_d  = rp_flags;
                end
                state_d = DONE;
            end
            DONE: begin
                if (mul_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mul_if.in_ready   = (state_q == IDLE);
    assign mul_if.out_valid  = (state_q == DONE);
    assign mul_if.out_result = result_q;
    assign mul_if.out_flags  = (state_q == DONE) ? flags_q : 4'd0;
    assign mul_if.busy       = (state_q != IDLE);
    assign state_o           = state_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
module tb_fp32_mul_seq;
    import fp32_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;
    state_e      st1;
    state_e      st4;

    always #5 clk = ~clk;

    fp32_mul_seq_if if1 ();
    fp32_mul_seq_if if4 ();

    assign if1.in_valid  = in_valid;
    assign if1.in_a      = in_a;
    assign if1.in_b      = in_b;
    assign if1.out_ready = out_ready;
    assign if4.in_valid  = in_valid;
    assign if4.in_a      = in_a;
    assign if4.in_b      = in_b;
    assign if4.out_ready = out_ready;

    fp32_mul_seq #(.MUL_RADIX(1)) dut1 (.clk(clk), .rst_n(rst_n), .mul_if(if1), .state_o(st1));
    fp32_mul_seq #(.MUL_RADIX(4)) dut4 (.clk(clk), .rst_n(rst_n), .mul_if(if4), .state_o(st4));

    int n_vec = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Reference model: exact integer product, then pick the representable
    // neighbour by comparing the discarded remainder with half an ulp.
    function automatic logic [35:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e, shift;
        logic            sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nx;
        longint unsigned p, mant, rem, half;
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        sign   = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        if (a_nan || b_nan) return {32'h7FC00000, 4'b0000};
        if ((a_zero && b_inf) || (a_inf && b_zero)) return {32'h7FC00000, 4'b1000};
        if (a_inf || b_inf) return {sign, 8'hFF, 23'd0, 4'b0000};
        if (a_zero || b_zero) return {sign, 31'd0, 4'b0000};
        p     = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e     = ea + eb - 127;
        shift = 23;
        if (p >= (64'd1 << 47)) begin
            shift = 24;
            e     = e + 1;
        end
        mant = p >> shift;
        rem  = p - (mant << shift);
        half = 64'd1 << (shift - 1);
        nx   = (rem != 0);
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {sign, 8'hFF, 23'd0, 4'b0101};
        if (e <= 0)   return {sign, 31'd0, 4'b0011};
        return {sign, 8'(e), mant[22:0], 3'b000, nx};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
    endfunction

    // ---------------- driver ----------------
    // Issues one operand pair to both multipliers and checks result, flags,
    // latency and that in_ready stays low until the result appears.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp_v,
                          input bit special, input string nm);
        int          lat1, lat4;
        bit          rdy_bad;
        logic [31:0] r1, r4;
        logic [3:0]  f1, f4;
        logic [35:0] e;
        lat1 = 0; lat4 = 0; rdy_bad = 0;
        r1 = '0; r4 = '0; f1 = '0; f4 = '0;
        exp_q.push_back(exp_v);
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({nm, " accept"}, {62'd0, if1.busy, if4.busy}, 64'd3);
        for (int c = 1; c <= 60 && (lat1 == 0 || lat4 == 0); c++) begin
            @(posedge clk);
            #1;
            if (lat1 == 0 && if1.out_valid) begin lat1 = c; r1 = if1.out_result; f1 = if1.out_flags; end
            if (lat4 == 0 && if4.out_valid) begin lat4 = c; r4 = if4.out_result; f4 = if4.out_flags; end
            if (lat1 == 0 && if1.in_ready) rdy_bad = 1'b1;
            if (lat4 == 0 && if4.in_ready) rdy_bad = 1'b1;
        end
        e = exp_q.pop_front();
        check({nm, " r1 result"}, 64'(r1), 64'(e[35:4]));
        check({nm, " r1 flags"},  64'(f1), 64'(e[3:0]));
        check({nm, " r4 result"}, 64'(r4), 64'(e[35:4]));
        check({nm, " r4 flags"},  64'(f4), 64'(e[3:0]));
        check({nm, " r1 latency"}, 64'(lat1), special ? 64'd2 : 64'd26);
        check({nm, " r4 latency"}, 64'(lat4), special ? 64'd2 : 64'd8);
        check({nm, " in_ready low while busy"}, 64'(rdy_bad), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({nm, " release"},
              {52'd0, if1.out_valid, if4.out_valid, if1.out_flags, if4.out_flags, if1.in_ready, if4.in_ready},
              64'd3);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        bit          special;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 1'b0}; // 3*2
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 1'b0}; // sticky round-down
        vecs[2]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 1'b0}; // negative
        vecs[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 1'b0}; // overflow
        vecs[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 1'b0}; // underflow to zero
        vecs[5]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1'b1}; // 0*inf
        vecs[6]  = '{32'h7FC00001, 32'h00000000, 32'h7FC00000, 4'b0000, 1'b1}; // NaN beats 0
        vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1'b1}; // -inf*2
        vecs[8]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1'b1}; // -0*1
        vecs[9]  = '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 1'b1}; // denormal flushed
        vecs[10] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 1'b0}; // tie, odd -> up
        vecs[11] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 1'b0}; // tie, even -> stay
        vecs[12] = '{32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 4'b0000, 1'b0}; // largest finite
    end

    // ---------------- test sequence ----------------
    initial begin
        int          waited;
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset r1 ready/valid/busy", {61'd0, if1.in_ready, if1.out_valid, if1.busy}, 64'd4);
        check("reset r4 ready/valid/busy", {61'd0, if4.in_ready, if4.out_valid, if4.busy}, 64'd4);
        check("reset result/flags", {28'd0, if1.out_result, if1.out_flags}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, {vecs[i].res, vecs[i].flg}, vecs[i].special,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready is low, and an
        // in_valid pulse during DONE must not be taken.
        @(negedge clk);
        in_a = 32'h40400000; in_b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        waited = 0;
        while (!if1.out_valid && waited < 60) begin
            @(posedge clk);
            #1 waited++;
        end
        check("bp reached DONE", 64'(if1.out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k == 1 || k == 2);
            in_a = 32'h3F800000; in_b = 32'h3F800000;
            @(posedge clk);
            #1;
            check($sformatf("bp hold cycle %0d", k),
                  {27'd0, if1.out_valid, if1.in_ready, if1.out_result, if1.out_flags},
                  {27'd0, 1'b1, 1'b0, 32'h40C00000, 4'b0000});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp pulse dropped", {62'd0, if1.busy, if4.busy}, 64'd0);

        // Reset during MULT abandons the operation.
        @(negedge clk);
        in_a = 32'h40400000; in_b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        check("mid-MULT state", 64'(st1), 64'(MULT));
        rst_n = 1'b0;
        #1;
        check("async reset r1", {60'd0, if1.in_ready, if1.out_valid, if1.busy, |if1.out_result}, 64'd8);
        check("async reset r4", {61'd0, if4.in_ready, if4.out_valid, if4.busy}, 64'd4);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40400000, 32'h40000000, {32'h40C00000, 4'b0000}, 1'b0, "after reset");

        // Randomised operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) != 0) ra[30:23] = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 7) != 0) rb[30:23] = 8'($urandom_range(60, 194));
            run_op(ra, rb, model_mul(ra, rb), is_special(ra, rb), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
